// File: rtl/multi_pulse_width_checker.sv
// Per-channel pulse width checker: measures each active pulse, flags short/long pulses.
// Optional width capture on last_width is enabled by defining PWC_LAST_WIDTH_EN.
module multi_pulse_width_checker #(
  parameter int                NUM_CH     = 4,
  parameter int                WIDTH_BITS = 16,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            pulse_in,
  input  logic [WIDTH_BITS-1:0]        min_pw,
  input  logic [WIDTH_BITS-1:0]        max_pw,
  input  logic [NUM_CH-1:0]            err_clr,
  output logic [NUM_CH-1:0]            result_valid,
  output logic [NUM_CH-1:0]            result_pass,
  output logic [NUM_CH-1:0]            err_short,
  output logic [NUM_CH-1:0]            err_long,
  output logic                         any_err,
  output logic [NUM_CH*WIDTH_BITS-1:0] last_width
);

  localparam logic [0:0]            IDLE     = 1'b0;
  localparam logic [0:0]            MEAS     = 1'b1;
  localparam logic [WIDTH_BITS-1:0] ALL_ONES = '1;

  logic [NUM_CH-1:0] short_nxt;
  logic [NUM_CH-1:0] long_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                  act, act_d, rise;
    logic [0:0]            state;
    logic [WIDTH_BITS-1:0] cnt, min_l, max_l;
    logic                  vld_q, pass_q, es_q, el_q;
    logic                  done, ovf, in_range, set_short, set_long;

    assign act  = pulse_in[i] ^ ACTIVE_LOW[i];
    assign rise = act & ~act_d;

    // An all-ones max disables the overflow cut-off so the counter saturates instead.
    assign done      = (state == MEAS) && !act;
    assign ovf       = (state == MEAS) && act && (cnt == max_l) && (max_l != ALL_ONES);
    assign in_range  = (cnt >= min_l) && (cnt <= max_l);
    assign set_short = done && !in_range && (cnt < min_l);
    assign set_long  = ovf || (done && !in_range && !(cnt < min_l));

    // A fresh error on the same edge as a clear takes priority.
    assign short_nxt[i] = set_short | (es_q & ~err_clr[i]);
    assign long_nxt[i]  = set_long  | (el_q & ~err_clr[i]);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state  <= IDLE;
        cnt    <= '0;
        act_d  <= 1'b1;
        vld_q  <= 1'b0;
        pass_q <= 1'b0;
        es_q   <= 1'b0;
        el_q   <= 1'b0;
      end else begin
        act_d <= act;
        vld_q <= done | ovf;
        es_q  <= short_nxt[i];
        el_q  <= long_nxt[i];
        if (done || ovf) pass_q <= done && in_range;
        case (state)
          IDLE: if (rise) begin
            state <= MEAS;
            cnt   <= WIDTH_BITS'(1);
          end
          default: begin
            if (done || ovf) state <= IDLE;
            else if (cnt < max_l) cnt <= cnt + WIDTH_BITS'(1);
          end
        endcase
      end
    end

    // Thresholds are frozen for the whole measurement.
    always_ff @(posedge clk) begin
      if (state == IDLE && rise) begin
        min_l <= min_pw;
        max_l <= max_pw;
      end
    end

`ifdef PWC_LAST_WIDTH_EN
    logic [WIDTH_BITS-1:0] lw_q;
    always_ff @(posedge clk) begin
      if (!rst_n) lw_q <= '0;
      else if (ovf) lw_q <= max_l + WIDTH_BITS'(1);
      else if (done) lw_q <= cnt;
    end
    assign last_width[i*WIDTH_BITS +: WIDTH_BITS] = lw_q;
`else
    assign last_width[i*WIDTH_BITS +: WIDTH_BITS] = '0;
`endif

    assign result_valid[i] = vld_q;
    assign result_pass[i]  = pass_q;
    assign err_short[i]    = es_q;
    assign err_long[i]     = el_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) any_err <= 1'b0;
    else        any_err <= |(short_nxt | long_nxt);
  end

endmodule

// File: tb/tb_multi_pulse_width_checker.sv
// Randomized and directed bench for multi_pulse_width_checker against a run-length reference model.
module tb_multi_pulse_width_checker;

  localparam int         NCH = 4;
  localparam int         WB  = 8;
  localparam logic [3:0] AL  = 4'b1000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] act_drv;
  logic [NCH-1:0] pulse_in;
  logic [WB-1:0]  min_pw, max_pw;
  logic [NCH-1:0] err_clr;
  logic [NCH-1:0] result_valid, result_pass, err_short, err_long;
  logic           any_err;
  logic [NCH*WB-1:0] last_width;

  assign pulse_in = act_drv ^ AL;

  multi_pulse_width_checker #(.NUM_CH(NCH), .WIDTH_BITS(WB), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .min_pw(min_pw), .max_pw(max_pw),
    .err_clr(err_clr), .result_valid(result_valid), .result_pass(result_pass),
    .err_short(err_short), .err_long(err_long), .any_err(any_err), .last_width(last_width)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes [NCH];

  // Reference model: counts active cycles of each pulse as a plain integer.
  bit       m_prev   [NCH];
  bit       m_meas   [NCH];
  int       m_run    [NCH];
  int       m_min    [NCH];
  int       m_max    [NCH];
  int       m_lw     [NCH];
  bit       m_pass   [NCH];
  logic [3:0] m_valid, m_short, m_long;
  logic       m_any;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset_state();
    for (int i = 0; i < NCH; i++) begin
      m_prev[i] = 1'b1; m_meas[i] = 1'b0; m_run[i] = 0; m_lw[i] = 0; m_pass[i] = 1'b0;
    end
    m_valid = '0; m_short = '0; m_long = '0; m_any = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset_state();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      bit a, ss, sl;
      a = pulse_in[i] ^ AL[i];
      ss = 1'b0; sl = 1'b0;
      m_valid[i] = 1'b0;
      if (m_meas[i]) begin
        if (!a) begin
          int w;
          w = (m_run[i] > 255) ? 255 : m_run[i];
          m_valid[i] = 1'b1;
          m_pass[i]  = (w >= m_min[i]) && (w <= m_max[i]);
          m_lw[i]    = w;
          if (!m_pass[i]) begin
            if (w < m_min[i]) ss = 1'b1;
            else              sl = 1'b1;
          end
          m_meas[i] = 1'b0;
        end else if (m_max[i] != 255 && m_run[i] + 1 > m_max[i]) begin
          m_valid[i] = 1'b1;
          m_pass[i]  = 1'b0;
          m_lw[i]    = m_max[i] + 1;
          sl         = 1'b1;
          m_meas[i]  = 1'b0;
        end else begin
          m_run[i]++;
        end
      end else if (a && !m_prev[i]) begin
        m_meas[i] = 1'b1;
        m_run[i]  = 1;
        m_min[i]  = int'(min_pw);
        m_max[i]  = int'(max_pw);
      end
      m_prev[i]  = a;
      m_short[i] = ss | (m_short[i] & ~err_clr[i]);
      m_long[i]  = sl | (m_long[i] & ~err_clr[i]);
    end
    m_any = |(m_short | m_long);
  endtask

  task automatic compare_all();
    check("result_valid", 64'(result_valid), 64'(m_valid));
    check("err_short", 64'(err_short), 64'(m_short));
    check("err_long", 64'(err_long), 64'(m_long));
    check("any_err", 64'(any_err), 64'(m_any));
    for (int i = 0; i < NCH; i++) begin
      strobes[i] += int'(result_valid[i]);
      if (m_valid[i]) check($sformatf("result_pass[%0d]", i), 64'(result_pass[i]), 64'(m_pass[i]));
`ifdef PWC_LAST_WIDTH_EN
      check($sformatf("last_width[%0d]", i), 64'(last_width[i*WB +: WB]), 64'(m_lw[i]));
`else
      check($sformatf("last_width[%0d]", i), 64'(last_width[i*WB +: WB]), 64'd0);
`endif
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < NCH; i++) strobes[i] = 0;
  endtask

  task automatic pulse(input int ch, input int len, input int gap);
    act_drv[ch] = 1'b1;
    step(len);
    act_drv[ch] = 1'b0;
    step(gap);
  endtask

  initial begin
    rst_n = 1'b0; act_drv = '0; err_clr = '0; min_pw = 8'd5; max_pw = 8'd20;
    model_reset_state();
    clear_strobes();

    // Reset with ch0 already active: must not be measured after release.
    act_drv[0] = 1'b1;
    step(3);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_width", 64'(last_width), 64'd0);
    rst_n = 1'b1;
    step(6);
    act_drv[0] = 1'b0;
    step(3);
    check("no_meas_at_release", 64'(strobes[0]), 64'd0);

    // 10-cycle pass on ch0.
    clear_strobes();
    pulse(0, 10, 4);
    check("ch0_one_strobe", 64'(strobes[0]), 64'd1);
`ifdef PWC_LAST_WIDTH_EN
    check("ch0_width10", 64'(last_width[7:0]), 64'd10);
`endif

    // 3-cycle short on ch1, then clear.
    pulse(1, 3, 3);
    check("ch1_short_set", 64'(err_short[1]), 64'd1);
    err_clr[1] = 1'b1; step(1); err_clr[1] = 1'b0;
    check("ch1_short_clr", 64'(err_short[1]), 64'd0);

    // 40-cycle hold on ch2: one strobe at overflow only.
    clear_strobes();
    pulse(2, 40, 4);
    check("ch2_one_strobe", 64'(strobes[2]), 64'd1);
    check("ch2_long", 64'(err_long[2]), 64'd1);

    // Low-active ch3: pass, then short, then clear coinciding with a new short.
    pulse(3, 5, 3);
    pulse(3, 2, 3);
    act_drv[3] = 1'b1; step(2);
    act_drv[3] = 1'b0; err_clr[3] = 1'b1; step(1); err_clr[3] = 1'b0;
    check("ch3_set_wins", 64'(err_short[3]), 64'd1);
    step(2);
    err_clr = '1; step(1); err_clr = '0;

    // 20-cycle pass, one idle cycle, 21-cycle overflow.
    pulse(0, 20, 1);
    pulse(0, 21, 4);
    check("ch0_long_b2b", 64'(err_long[0]), 64'd1);

    // Saturation with all-ones max.
    max_pw = 8'hFF;
    clear_strobes();
    pulse(1, 300, 3);
    check("ch1_sat_strobe", 64'(strobes[1]), 64'd1);
    check("ch1_sat_pass", 64'(err_long[1]), 64'd0);

    // min > max.
    min_pw = 8'd10; max_pw = 8'd5;
    pulse(2, 3, 3);
    pulse(2, 8, 4);

    // Reset mid-pulse on all channels.
    min_pw = 8'd5; max_pw = 8'd20;
    act_drv = '1; step(4);
    rst_n = 1'b0; step(1);
    check("midrst_all_zero", 64'({result_valid, result_pass, err_short, err_long, any_err}), 64'd0);
    rst_n = 1'b1; step(3);
    act_drv = '0; step(3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 5) == 0) act_drv[i] = ~act_drv[i];
      err_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 40) == 0) begin
        min_pw = 8'($urandom_range(1, 12));
        max_pw = 8'($urandom_range(1, 25));
      end
      rst_n = ($urandom_range(0, 600) != 0);
      step(1);
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
